register: RTL and testbench
===========================

REGISTER -- requirements
Module: register

Interface
REQ-001 Parameter DATA_WIDTH, default 16; width of d and q in bits; any value >= 1 SHALL be supported.
REQ-002 Parameter RESET_VALUE, default 0 (DATA_WIDTH bits); value loaded into q by reset or clear.
REQ-003 Parameter LANE_WIDTH, default 8; width of one write-mask lane; last lane SHALL be partial when DATA_WIDTH is not a multiple.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge only.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 d  input  DATA_WIDTH  write data.
REQ-007 q  output  DATA_WIDTH  stored value, driven directly from flops.
REQ-008 hold  input  1  active-high; when 1, q SHALL keep its value.
REQ-009 clr  input  1  active-high synchronous clear to RESET_VALUE.
REQ-010 wmask_n  input  ceil(DATA_WIDTH/LANE_WIDTH)  active-low per-lane write inhibit; bit i covers q lane i, lane 0 holding the LSBs.
REQ-011 Port declaration order SHALL be d, clk, q, rst, hold, clr, wmask_n, so that a three-port positional instance (d, clk, q) connects correctly.

Function
REQ-012 On each rising clk edge with rst=0, priority SHALL be: clr=1 -> q<=RESET_VALUE; else hold=1 -> q unchanged; else each lane i with wmask_n[i]=0 loads d lane i and each lane with wmask_n[i]=1 keeps its value.
REQ-013 Load latency SHALL be one edge: d sampled at edge N appears on q immediately after edge N and is held until the next qualifying edge.
REQ-014 d changes between edges, including glitches shorter than a clock phase, SHALL NOT affect q.
REQ-015 hold, clr and wmask_n inputs that are 0 or undriven (Z) SHALL NOT clear, hold or inhibit; conditions SHALL be tested as "== 1", so a floating pin yields plain register behaviour.
REQ-016 clr=1 together with hold=1 SHALL clear; clr overrides wmask_n.
REQ-017 No combinational path from d to q.

Reset
REQ-018 rst=1 SHALL set q to RESET_VALUE immediately, independent of clk.
REQ-019 While rst=1, clock edges SHALL be ignored.
REQ-020 The first rising edge after rst falls SHALL load normally per REQ-012.
REQ-021 If rst is never asserted, q SHALL be unknown until the first loading edge.

Configuration
REQ-022 Macro REGISTER_PARITY_EN defined: an extra output q_par (1 bit, declared after wmask_n) SHALL be the registered even parity (XOR) of the stored q.
REQ-023 With REGISTER_PARITY_EN defined, q_par SHALL update on the same edges as q, use the same reset/clear and lane semantics, and reset to the parity of RESET_VALUE.
REQ-024 Macro REGISTER_PARITY_EN undefined: the q_par port and its logic SHALL be absent; all other behaviour is unchanged.

Structure
REQ-025 Package register_pkg SHALL hold DEFAULT_DATA_WIDTH=16, DEFAULT_LANE_WIDTH=8 and a lane-count function ceil(DATA_WIDTH/LANE_WIDTH).
REQ-026 Per-lane storage SHALL be a sub-module register_lane, instantiated once per lane in a generate loop; each register_lane holds its own rst/clr/hold/mask logic and a LANE_WIDTH-or-shorter data slice.

Verification
REQ-027 Free-running clk with 10 ns period, first rising edge at 5 ns, rst/hold/clr/wmask_n left unconnected -> q=xxxx before 5 ns; d=0003 -> q=0003 after 5 ns.
REQ-028 d sequence 0009@10, 8031@13, 0006@14 -> q=0006 after the 15 ns edge; the intermediate values never appear on q.
REQ-029 d=0003@18, 0008@26, FFFF@32, 0000@39, 0003@46 -> q=0003@25, FFFF@35, 0000@45, 0003@55 (the 0008 value is never captured).
REQ-030 q=FFFF, rst pulsed 1 mid-cycle for 2 ns -> q=0000 immediately; following edge with d=1234 -> q=1234.
REQ-031 q=0000, d=ABCD, wmask_n=2'b10 -> q=00CD; then hold=1, clr=1 -> q=0000; then hold=1 alone, d=5555 -> q stays 0000.
REQ-032 With REGISTER_PARITY_EN defined: d=0007 loaded -> q_par=1; d=0003 loaded -> q_par=0.

Source files
------------

// File: rtl/register_pkg.sv
// Shared sizing defaults and lane-count helper for the lane-masked register.
package register_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_LANE_WIDTH = 8;

    function automatic int lane_count(input int data_width, input int lane_width);
        return (data_width + lane_width - 1) / lane_width;
    endfunction

endpackage

// File: rtl/register_lane.sv
// One write-mask lane of the register: async reset, sync clear, hold, per-lane inhibit.
// Latency 1 edge; no backpressure.
module register_lane #(
    parameter int                 WIDTH       = 8,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic [WIDTH-1:0] d,
    input  logic             clk,
    output logic [WIDTH-1:0] q,
    input  logic             rst,
    input  logic             hold,
    input  logic             clr,
    input  logic             wmask_n
);

    // Every control is compared against 1 so a floating (X/Z) pin falls through to a plain load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_VALUE;
        end else if (clr == 1'b1) begin
            q <= RESET_VALUE;
        end else if (hold == 1'b1) begin
            q <= q;
        end else if (wmask_n == 1'b1) begin
            q <= q;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/register.sv
// Lane-masked D register with hold and clear; REGISTER_PARITY_EN adds a registered parity output q_par.
// Latency 1 edge from d to q; no backpressure (hold/wmask_n simply keep stored lanes).
module register
    import register_pkg::*;
#(
    parameter int                      DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0]   RESET_VALUE = '0,
    parameter int                      LANE_WIDTH  = DEFAULT_LANE_WIDTH,
    localparam int                     NUM_LANES   = lane_count(DATA_WIDTH, LANE_WIDTH)
) (
    input  logic [DATA_WIDTH-1:0] d,
    input  logic                  clk,
    output logic [DATA_WIDTH-1:0] q,
    input  logic                  rst,
    input  logic                  hold,
    input  logic                  clr,
    input  logic [NUM_LANES-1:0]  wmask_n
`ifdef REGISTER_PARITY_EN
    ,
    output logic                  q_par
`endif
);

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        localparam int LO = i * LANE_WIDTH;
        // The top lane is shortened when DATA_WIDTH is not a multiple of LANE_WIDTH.
        localparam int W  = (DATA_WIDTH - LO < LANE_WIDTH) ? (DATA_WIDTH - LO) : LANE_WIDTH;

        register_lane #(
            .WIDTH       (W),
            .RESET_VALUE (RESET_VALUE[LO +: W])
        ) u_lane (
            .d       (d[LO +: W]),
            .clk     (clk),
            .q       (q[LO +: W]),
            .rst     (rst),
            .hold    (hold),
            .clr     (clr),
            .wmask_n (wmask_n[i])
        );
    end

`ifdef REGISTER_PARITY_EN
    logic [DATA_WIDTH-1:0] q_next;

    // Parity is taken from the value the lanes will store, so it lands on the same edge as q.
    for (genvar j = 0; j < NUM_LANES; j++) begin : g_next
        localparam int LO = j * LANE_WIDTH;
        localparam int W  = (DATA_WIDTH - LO < LANE_WIDTH) ? (DATA_WIDTH - LO) : LANE_WIDTH;

        assign q_next[LO +: W] = (wmask_n[j] == 1'b1) ? q[LO +: W] : d[LO +: W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_par <= ^RESET_VALUE;
        end else if (clr == 1'b1) begin
            q_par <= ^RESET_VALUE;
        end else if (hold == 1'b1) begin
            q_par <= q_par;
        end else begin
            q_par <= ^q_next;
        end
    end
`endif

endmodule

// File: tb/tb_register.sv
// Directed timeline bench for the lane-masked register (default 16-bit, 8-bit lanes).
`timescale 1ns/1ps
module tb_register;

    logic [15:0] d;
    logic        clk;
    logic [15:0] q;
    logic        rst;
    logic        hold;
    logic        clr;
    logic [1:0]  wmask_n;
`ifdef REGISTER_PARITY_EN
    logic        q_par;
`endif

    int n_asserts = 0;
    int n_fails   = 0;

    register dut (
        .d       (d),
        .clk     (clk),
        .q       (q),
        .rst     (rst),
        .hold    (hold),
        .clr     (clr),
        .wmask_n (wmask_n)
`ifdef REGISTER_PARITY_EN
        ,
        .q_par   (q_par)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic at(input int t);
        if ($time < t) #(t - $time);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0; hold = 1'b0; clr = 1'b0; wmask_n = 2'b00;
        d = 16'h0003;
        at(7);   chk("first_load", q, 16'h0003);
        at(10);  d = 16'h0009;
        at(12);  chk("no_mid_cycle_change", q, 16'h0003);
        at(13);  d = 16'h8031;
        at(14);  d = 16'h0006;
        at(17);  chk("last_before_edge", q, 16'h0006);
        at(18);  d = 16'h0003;
        at(26);  d = 16'h0008;
        at(27);  chk("load_0003", q, 16'h0003);
        at(32);  d = 16'hFFFF;
        at(33);  chk("0008_not_captured", q, 16'h0003);
        at(37);  chk("load_ffff", q, 16'hFFFF);
        at(39);  d = 16'h0000;
        at(46);  d = 16'h0003;
        at(47);  chk("load_0000", q, 16'h0000);
        at(57);  chk("reload_0003", q, 16'h0003);
        at(58);  d = 16'hFFFF;
        at(67);  chk("pre_reset_ffff", q, 16'hFFFF);
        at(68);  rst = 1'b1;
        at(69);  chk("async_reset", q, 16'h0000);
        at(70);  rst = 1'b0; d = 16'h1234;
        at(77);  chk("load_after_reset", q, 16'h1234);
        at(78);  rst = 1'b1; d = 16'h7777;
        at(87);  chk("edge_ignored_in_reset", q, 16'h0000);
        at(88);  rst = 1'b0;
        at(97);  chk("first_edge_after_reset", q, 16'h7777);
        at(98);  clr = 1'b1;
        at(107); chk("clear", q, 16'h0000);
        at(108); clr = 1'b0; d = 16'hABCD; wmask_n = 2'b10;
        at(117); chk("mask_upper_lane", q, 16'h00CD);
        at(118); hold = 1'b1; clr = 1'b1;
        at(127); chk("clr_beats_hold_and_mask", q, 16'h0000);
        at(128); clr = 1'b0; wmask_n = 2'b00; d = 16'h5555;
        at(137); chk("hold_keeps", q, 16'h0000);
        at(138); hold = 1'b0; wmask_n = 2'b01;
        at(147); chk("mask_lower_lane", q, 16'h5500);
        at(148); wmask_n = 2'b11; d = 16'h1111;
        at(157); chk("mask_both_lanes", q, 16'h5500);
`ifdef REGISTER_PARITY_EN
        at(158); wmask_n = 2'b00; d = 16'h0007;
        at(167); chk("load_0007", q, 16'h0007);
                 chk("parity_0007", {15'd0, q_par}, 16'd1);
        at(168); d = 16'h0003;
        at(177); chk("parity_0003", {15'd0, q_par}, 16'd0);
        at(178); d = 16'h0001;
        at(187); chk("parity_0001", {15'd0, q_par}, 16'd1);
        at(188); rst = 1'b1;
        at(189); chk("parity_reset", {15'd0, q_par}, 16'd0);
        at(190); rst = 1'b0;
`endif
        at(200);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
